sdram_req_queue: RTL and testbench
==================================

SDRAM_REQ_QUEUE -- requirements
Module: sdram_req_queue

Interface
REQ-001 The block SHALL have one clock and asynchronous, active-high reset; all state SHALL clear immediately on reset assertion.
REQ-002 Parameter: DEPTH, default 4, queue entries; a power of two, min 2.
REQ-003 Parameter: ADDR_W, default 22, request address width.
REQ-004 Parameter: DATA_W, default 32, data width.
REQ-005 Port: clk  in  1  system clock, 100/130 MHz.
REQ-006 Port: reset  in  1  async active-high reset.
REQ-007 Ports: az_cs, az_rd_n, az_wr_n  in  1 each  chip enable, active-low read, active-low write.
REQ-008 Ports: az_be_n  in  4 (az_addr  in  ADDR_W; az_data  in  DATA_W)  byte-enable mask (active-low), address, write data.
REQ-009 Ports: za_waitrequest  out  1 (za_valid  out  1; za_data  out  DATA_W)  stall, read-data valid, read data.
REQ-010 Ports: req_valid  out  1 (req_ready  in  1)  request offered to command issuer; issuer accepts.
REQ-011 Ports: req_we  out  1 (req_be_n  out  4; req_addr  out  ADDR_W; req_wdata  out  DATA_W)  head-entry fields.
REQ-012 Ports: rd_valid  in  1 (rd_data  in  DATA_W)  read data returned from SDRAM data bus.

Function
REQ-013 A request SHALL be accepted on a rising edge when az_cs=1, za_waitrequest=0, and exactly one of az_rd_n/az_wr_n is 0.
REQ-014 If az_rd_n=az_wr_n=0 with az_cs=1, the cycle SHALL be dropped; no entry is written.
REQ-015 An accepted entry SHALL store {we=~az_wr_n, be_n, addr, data}; for reads, data is don't-care.
REQ-016 req_valid SHALL rise in the cycle after the first accept into an empty queue (latency 1, no fall-through).
REQ-017 The head SHALL pop on an edge with req_valid=1 and req_ready=1; req_* SHALL hold stable while req_valid=1 and req_ready=0.
REQ-018 A simultaneous push and pop SHALL leave the count unchanged; this also applies at count 1.
REQ-019 Read/write pointers SHALL wrap modulo DEPTH; occupancy counter width SHALL be clog2(DEPTH)+1.
REQ-020 za_waitrequest SHALL be a registered output equal to (count==DEPTH) or (rd_outstanding==DEPTH), updated from next-state values.
REQ-021 rd_outstanding SHALL increment on accept of a read and decrement on rd_valid; if both occur together, it SHALL be unchanged.
REQ-022 On rd_valid=1 with rd_outstanding>0, za_valid SHALL be 1 and za_data=rd_data on the next cycle, for one cycle only.
REQ-023 rd_valid with rd_outstanding=0 SHALL be ignored; za_valid stays 0 and the counter does not underflow.
REQ-024 Read data SHALL return in issue order; the block performs no reordering.

Reset
REQ-025 On reset, the following SHALL be 0: za_valid, za_data, req_valid, req_we, req_be_n, req_addr, req_wdata, pointers, count, rd_outstanding.
REQ-026 On reset, za_waitrequest SHALL be 1 for the reset period and the first cycle after release, then reflect REQ-020.
REQ-027 Reset mid-operation SHALL flush all entries and outstanding-read tracking; rd_valid data arriving afterwards SHALL be dropped per REQ-023.

Configuration
REQ-028 With SDRAM_REQ_LEVEL_EN defined, the block SHALL add output q_level [clog2(DEPTH):0], equal to the registered occupancy count, reset 0.
REQ-029 Without SDRAM_REQ_LEVEL_EN, the q_level port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 The shared package sdram_pkg SHALL hold the ADDR_W/DATA_W defaults, the entry field widths, and the packed entry width (1+4+ADDR_W+DATA_W).
REQ-031 Storage and pointers SHALL live in one sub-module, sdram_req_fifo (sync FIFO: push, pop, full, empty, count); handshake and read tracking stay in the top.

Verification
REQ-032 Single write az_addr=0x00010, az_data=0xDEADBEEF, az_be_n=0x0, req_ready=1 -> req_valid 1 cycle later with req_we=1, req_addr=0x00010, req_wdata=0xDEADBEEF; queue empty afterwards.
REQ-033 Five writes back-to-back with req_ready=0, DEPTH=4 -> za_waitrequest=1 after the 4th accept; 5th held until one pop, then accepted.
REQ-034 Two reads, then rd_valid pulses with 0x11111111 then 0x22222222 -> za_valid pulses two cycles, za_data in the same order; rd_outstanding returns to 0.
REQ-035 az_rd_n=az_wr_n=0 with az_cs=1 -> no req_valid; count stays 0. Also: a spurious rd_valid with none outstanding -> za_valid stays 0.
REQ-036 Reset asserted with 3 entries queued and 2 reads outstanding -> next cycle req_valid=0, za_valid=0, za_waitrequest=1; after release, a new write passes per REQ-032.
REQ-037 Push and pop on the same edge at count 1 and at count DEPTH-1 -> count unchanged and data order preserved; with SDRAM_REQ_LEVEL_EN, q_level matches count throughout.

Source files
------------

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared widths and entry packing for the SDRAM request queue
package sdram_pkg;

  localparam int ADDR_W_DEF = 22;
  localparam int DATA_W_DEF = 32;
  localparam int WE_W       = 1;
  localparam int BE_W       = 4;

  // Packed entry layout, MSB first: {we, be_n, addr, data}
  function automatic int entry_w(input int addr_w, input int data_w);
    return WE_W + BE_W + addr_w + data_w;
  endfunction

  localparam int ENTRY_W_DEF = entry_w(ADDR_W_DEF, DATA_W_DEF);

endpackage

// File: rtl/sdram_req_fifo.sv
// rtl/sdram_req_fifo.sv - synchronous request FIFO holding packed queue entries
module sdram_req_fifo
  import sdram_pkg::*;
#(
  parameter int WIDTH = ENTRY_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage, power-of-two wrapping pointers and occupancy; contents clear on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sdram_req_queue.sv
// rtl/sdram_req_queue.sv - SDRAM request queue with read tracking; q_level port under SDRAM_REQ_LEVEL_EN
module sdram_req_queue
  import sdram_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   az_cs,
  input  logic                   az_rd_n,
  input  logic                   az_wr_n,
  input  logic [BE_W-1:0]        az_be_n,
  input  logic [ADDR_W-1:0]      az_addr,
  input  logic [DATA_W-1:0]      az_data,
  output logic                   za_waitrequest,
  output logic                   za_valid,
  output logic [DATA_W-1:0]      za_data,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic                   req_we,
  output logic [BE_W-1:0]        req_be_n,
  output logic [ADDR_W-1:0]      req_addr,
  output logic [DATA_W-1:0]      req_wdata,
`ifdef SDRAM_REQ_LEVEL_EN
  output logic [$clog2(DEPTH):0] q_level,
`endif
  input  logic                   rd_valid,
  input  logic [DATA_W-1:0]      rd_data
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = entry_w(ADDR_W, DATA_W);

  logic          accept;
  logic          rd_accept;
  logic          pop;
  logic          rd_ret;
  logic          fifo_full;
  logic          fifo_empty;
  logic          init_q;
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head_entry;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [CW-1:0] rd_outstanding;
  logic [CW-1:0] rd_out_next;

  // A cycle with both strobes low is ambiguous and is dropped rather than guessed
  assign accept     = az_cs & ~za_waitrequest & (az_rd_n ^ az_wr_n);
  assign rd_accept  = accept & ~az_rd_n;
  assign pop        = req_valid & req_ready;
  assign rd_ret     = rd_valid & (rd_outstanding != '0);
  assign push_entry = {~az_wr_n, az_be_n, az_addr, az_data};

  sdram_req_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept & ~fifo_full),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign req_valid = ~fifo_empty;
  assign {req_we, req_be_n, req_addr, req_wdata} = head_entry;

`ifdef SDRAM_REQ_LEVEL_EN
  assign q_level = count;
`endif

  // Next-state occupancy and outstanding-read counts feeding the registered stall
  always_comb begin
    count_next  = count + CW'(accept) - CW'(pop);
    rd_out_next = rd_outstanding + CW'(rd_accept) - CW'(rd_ret);
  end

  // Outstanding-read tracker; a return with nothing outstanding is ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_outstanding <= '0;
    else       rd_outstanding <= rd_out_next;
  end

  // Read data is forwarded one cycle after a tracked return, in arrival order
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      za_valid <= 1'b0;
      za_data  <= '0;
    end else begin
      za_valid <= rd_ret;
      if (rd_ret) za_data <= rd_data;
    end
  end

  // Registered stall; init_q holds it high through the first clock after reset release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_q         <= 1'b1;
      za_waitrequest <= 1'b1;
    end else begin
      init_q         <= 1'b0;
      za_waitrequest <= init_q | (count_next == CW'(DEPTH)) | (rd_out_next == CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_sdram_req_queue.sv
// tb/tb_sdram_req_queue.sv - directed self-checking bench for sdram_req_queue
module tb_sdram_req_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;

  logic              clk       = 1'b0;
  logic              reset     = 1'b0;
  logic              az_cs     = 1'b0;
  logic              az_rd_n   = 1'b1;
  logic              az_wr_n   = 1'b1;
  logic [3:0]        az_be_n   = 4'hF;
  logic [ADDR_W-1:0] az_addr   = '0;
  logic [DATA_W-1:0] az_data   = '0;
  logic              req_ready = 1'b0;
  logic              rd_valid  = 1'b0;
  logic [DATA_W-1:0] rd_data   = '0;
  logic              za_waitrequest;
  logic              za_valid;
  logic [DATA_W-1:0] za_data;
  logic              req_valid;
  logic              req_we;
  logic [3:0]        req_be_n;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
`ifdef SDRAM_REQ_LEVEL_EN
  logic [$clog2(DEPTH):0] q_level;
`endif

  int n_cmp = 0;
  int n_err = 0;

  sdram_req_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .az_cs          (az_cs),
    .az_rd_n        (az_rd_n),
    .az_wr_n        (az_wr_n),
    .az_be_n        (az_be_n),
    .az_addr        (az_addr),
    .az_data        (az_data),
    .za_waitrequest (za_waitrequest),
    .za_valid       (za_valid),
    .za_data        (za_data),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_be_n       (req_be_n),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
`ifdef SDRAM_REQ_LEVEL_EN
    .q_level        (q_level),
`endif
    .rd_valid       (rd_valid),
    .rd_data        (rd_data)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({za_waitrequest, za_valid, req_valid} !== 3'b100) begin
      n_err++; $display("FAIL reset_async_flags: got %b want 100", {za_waitrequest, za_valid, req_valid});
    end
    step;
    step;
    n_cmp++;
    if ({req_we, req_be_n, req_addr, req_wdata, za_data} !== '0) begin
      n_err++; $display("FAIL reset_fields: got we=%b be_n=%h addr=%h wdata=%h za_data=%h want all 0",
                        req_we, req_be_n, req_addr, req_wdata, za_data);
    end
    n_cmp++;
    if (za_waitrequest !== 1'b1) begin
      n_err++; $display("FAIL reset_wait_hold: got %b want 1", za_waitrequest);
    end
    reset = 1'b0;
    step;
    n_cmp++;
    if (za_waitrequest !== 1'b1) begin
      n_err++; $display("FAIL reset_wait_first_cycle: got %b want 1", za_waitrequest);
    end
    step;
    n_cmp++;
    if ({za_waitrequest, req_valid, dut.u_fifo.count} !== {1'b0, 1'b0, 3'd0}) begin
      n_err++; $display("FAIL reset_wait_release: got wait=%b valid=%b count=%0d want 0 0 0",
                        za_waitrequest, req_valid, dut.u_fifo.count);
    end
  endtask

  task automatic test_single_write;
    req_ready = 1'b1;
    az_cs = 1'b1; az_rd_n = 1'b1; az_wr_n = 1'b0; az_be_n = 4'h0;
    az_addr = 22'h00010; az_data = 32'hDEADBEEF;
    step;
    az_cs = 1'b0; az_wr_n = 1'b1;
    n_cmp++;
    if ({req_valid, req_we, req_be_n, req_addr, req_wdata} !== {1'b1, 1'b1, 4'h0, 22'h00010, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL single_write_head: got v=%b we=%b be_n=%h addr=%h wdata=%h want 1 1 0 00010 deadbeef",
                        req_valid, req_we, req_be_n, req_addr, req_wdata);
    end
    step;
    n_cmp++;
    if ({req_valid, dut.u_fifo.count} !== {1'b0, 3'd0}) begin
      n_err++; $display("FAIL single_write_drain: got valid=%b count=%0d want 0 0", req_valid, dut.u_fifo.count);
    end
  endtask

  task automatic test_full;
    int acc = 0;
    int cyc = 0;
    req_ready = 1'b0;
    az_cs = 1'b1; az_rd_n = 1'b1; az_wr_n = 1'b0; az_be_n = 4'h0;
    while (acc < 4 && cyc < 20) begin
      az_addr = 22'(acc);
      az_data = 32'hA000_0000 + 32'(acc);
      if (!za_waitrequest) acc++;
      step;
      cyc++;
    end
    n_cmp++;
    if (acc !== 4) begin
      n_err++; $display("FAIL full_fill_timeout: got %0d accepts want 4", acc);
    end
    n_cmp++;
    if ({za_waitrequest, req_valid, req_addr} !== {1'b1, 1'b1, 22'h0}) begin
      n_err++; $display("FAIL full_wait: got wait=%b valid=%b addr=%h want 1 1 0", za_waitrequest, req_valid, req_addr);
    end
    az_addr = 22'h4; az_data = 32'hA000_0004;
    for (int k = 0; k < 3; k++) begin
      step;
      n_cmp++;
      if ({za_waitrequest, req_addr, req_wdata, dut.u_fifo.count} !== {1'b1, 22'h0, 32'hA000_0000, 3'd4}) begin
        n_err++; $display("FAIL full_hold_%0d: got wait=%b addr=%h wdata=%h count=%0d want 1 0 a0000000 4",
                          k, za_waitrequest, req_addr, req_wdata, dut.u_fifo.count);
      end
    end
    req_ready = 1'b1;
    step;
    req_ready = 1'b0;
    n_cmp++;
    if ({za_waitrequest, dut.u_fifo.count} !== {1'b0, 3'd3}) begin
      n_err++; $display("FAIL full_after_pop: got wait=%b count=%0d want 0 3", za_waitrequest, dut.u_fifo.count);
    end
    step;
    az_cs = 1'b0; az_wr_n = 1'b1;
    n_cmp++;
    if ({za_waitrequest, dut.u_fifo.count} !== {1'b1, 3'd4}) begin
      n_err++; $display("FAIL full_fifth_accept: got wait=%b count=%0d want 1 4", za_waitrequest, dut.u_fifo.count);
    end
    req_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      n_cmp++;
      if ({req_valid, req_addr, req_wdata} !== {1'b1, 22'(j), 32'hA000_0000 + 32'(j)}) begin
        n_err++; $display("FAIL full_drain_%0d: got v=%b addr=%h wdata=%h want 1 %h %h",
                          j, req_valid, req_addr, req_wdata, 22'(j), 32'hA000_0000 + 32'(j));
      end
      step;
    end
    n_cmp++;
    if ({req_valid, za_waitrequest} !== 2'b00) begin
      n_err++; $display("FAIL full_empty: got valid=%b wait=%b want 0 0", req_valid, za_waitrequest);
    end
  endtask

  task automatic test_reads;
    req_ready = 1'b1;
    az_cs = 1'b1; az_rd_n = 1'b0; az_wr_n = 1'b1; az_be_n = 4'h0; az_addr = 22'h100;
    step;
    az_addr = 22'h104;
    n_cmp++;
    if ({req_valid, req_we, req_addr} !== {1'b1, 1'b0, 22'h100}) begin
      n_err++; $display("FAIL read1_head: got v=%b we=%b addr=%h want 1 0 100", req_valid, req_we, req_addr);
    end
    step;
    az_cs = 1'b0; az_rd_n = 1'b1;
    n_cmp++;
    if ({req_valid, req_we, req_addr, dut.rd_outstanding} !== {1'b1, 1'b0, 22'h104, 3'd2}) begin
      n_err++; $display("FAIL read2_head: got v=%b we=%b addr=%h outst=%0d want 1 0 104 2",
                        req_valid, req_we, req_addr, dut.rd_outstanding);
    end
    rd_valid = 1'b1; rd_data = 32'h11111111;
    step;
    rd_data = 32'h22222222;
    n_cmp++;
    if ({za_valid, za_data} !== {1'b1, 32'h11111111}) begin
      n_err++; $display("FAIL read_ret1: got v=%b data=%h want 1 11111111", za_valid, za_data);
    end
    step;
    rd_valid = 1'b0;
    n_cmp++;
    if ({za_valid, za_data} !== {1'b1, 32'h22222222}) begin
      n_err++; $display("FAIL read_ret2: got v=%b data=%h want 1 22222222", za_valid, za_data);
    end
    step;
    n_cmp++;
    if ({za_valid, req_valid, dut.rd_outstanding} !== {1'b0, 1'b0, 3'd0}) begin
      n_err++; $display("FAIL read_done: got zv=%b rv=%b outst=%0d want 0 0 0", za_valid, req_valid, dut.rd_outstanding);
    end
  endtask

  task automatic test_illegal;
    req_ready = 1'b1;
    az_cs = 1'b1; az_rd_n = 1'b0; az_wr_n = 1'b0; az_addr = 22'h200;
    for (int k = 0; k < 2; k++) begin
      step;
      n_cmp++;
      if ({req_valid, dut.u_fifo.count, dut.rd_outstanding} !== {1'b0, 3'd0, 3'd0}) begin
        n_err++; $display("FAIL illegal_drop_%0d: got v=%b count=%0d outst=%0d want 0 0 0",
                          k, req_valid, dut.u_fifo.count, dut.rd_outstanding);
      end
    end
    az_cs = 1'b0; az_rd_n = 1'b1; az_wr_n = 1'b1;
    rd_valid = 1'b1; rd_data = 32'h33333333;
    step;
    rd_valid = 1'b0;
    n_cmp++;
    if ({za_valid, dut.rd_outstanding, za_waitrequest} !== {1'b0, 3'd0, 1'b0}) begin
      n_err++; $display("FAIL spurious_rd: got zv=%b outst=%0d wait=%b want 0 0 0", za_valid, dut.rd_outstanding, za_waitrequest);
    end
  endtask

  task automatic test_reset_mid;
    req_ready = 1'b0;
    az_cs = 1'b1; az_rd_n = 1'b1; az_wr_n = 1'b0; az_be_n = 4'h3; az_addr = 22'h30; az_data = 32'h0000_0030;
    step;
    az_rd_n = 1'b0; az_wr_n = 1'b1; az_addr = 22'h34;
    step;
    az_addr = 22'h38;
    step;
    az_cs = 1'b0; az_rd_n = 1'b1;
    n_cmp++;
    if ({req_valid, dut.u_fifo.count, dut.rd_outstanding} !== {1'b1, 3'd3, 3'd2}) begin
      n_err++; $display("FAIL mid_setup: got v=%b count=%0d outst=%0d want 1 3 2", req_valid, dut.u_fifo.count, dut.rd_outstanding);
    end
    reset = 1'b1; rd_valid = 1'b1; rd_data = 32'h55555555;
    #1;
    n_cmp++;
    if ({req_valid, za_waitrequest} !== 2'b01) begin
      n_err++; $display("FAIL mid_async: got v=%b wait=%b want 0 1", req_valid, za_waitrequest);
    end
    step;
    n_cmp++;
    if ({req_valid, za_valid, za_waitrequest} !== 3'b001) begin
      n_err++; $display("FAIL mid_reset: got rv=%b zv=%b wait=%b want 0 0 1", req_valid, za_valid, za_waitrequest);
    end
    reset = 1'b0;
    step;
    rd_valid = 1'b0;
    n_cmp++;
    if ({za_valid, za_waitrequest} !== 2'b01) begin
      n_err++; $display("FAIL mid_release: got zv=%b wait=%b want 0 1", za_valid, za_waitrequest);
    end
    step;
    n_cmp++;
    if ({za_valid, za_waitrequest, dut.rd_outstanding} !== {1'b0, 1'b0, 3'd0}) begin
      n_err++; $display("FAIL mid_flushed: got zv=%b wait=%b outst=%0d want 0 0 0", za_valid, za_waitrequest, dut.rd_outstanding);
    end
    test_single_write();
  endtask

  task automatic test_push_pop;
    req_ready = 1'b0;
    az_cs = 1'b1; az_rd_n = 1'b1; az_wr_n = 1'b0; az_be_n = 4'h5;
    az_addr = 22'h20; az_data = 32'hB0;
    step;
    az_addr = 22'h21; az_data = 32'hB1; req_ready = 1'b1;
    step;
    req_ready = 1'b0;
    n_cmp++;
    if ({dut.u_fifo.count, req_valid, req_addr, req_wdata} !== {3'd1, 1'b1, 22'h21, 32'hB1}) begin
      n_err++; $display("FAIL pp_count1: got count=%0d v=%b addr=%h wdata=%h want 1 1 21 b1",
                        dut.u_fifo.count, req_valid, req_addr, req_wdata);
    end
`ifdef SDRAM_REQ_LEVEL_EN
    n_cmp++;
    if (q_level !== 3'd1) begin
      n_err++; $display("FAIL pp_level1: got %0d want 1", q_level);
    end
`endif
    az_addr = 22'h22; az_data = 32'hB2;
    step;
    az_addr = 22'h23; az_data = 32'hB3;
    step;
    az_addr = 22'h24; az_data = 32'hB4; req_ready = 1'b1;
    step;
    az_cs = 1'b0; az_wr_n = 1'b1;
    n_cmp++;
    if ({dut.u_fifo.count, za_waitrequest, req_be_n} !== {3'd3, 1'b0, 4'h5}) begin
      n_err++; $display("FAIL pp_count3: got count=%0d wait=%b be_n=%h want 3 0 5", dut.u_fifo.count, za_waitrequest, req_be_n);
    end
`ifdef SDRAM_REQ_LEVEL_EN
    n_cmp++;
    if (q_level !== 3'd3) begin
      n_err++; $display("FAIL pp_level3: got %0d want 3", q_level);
    end
`endif
    for (int j = 2; j <= 4; j++) begin
      n_cmp++;
      if ({req_valid, req_addr, req_wdata} !== {1'b1, 22'h20 + 22'(j), 32'hB0 + 32'(j)}) begin
        n_err++; $display("FAIL pp_order_%0d: got v=%b addr=%h wdata=%h want 1 %h %h",
                          j, req_valid, req_addr, req_wdata, 22'h20 + 22'(j), 32'hB0 + 32'(j));
      end
      step;
    end
    n_cmp++;
    if ({req_valid, dut.u_fifo.count} !== {1'b0, 3'd0}) begin
      n_err++; $display("FAIL pp_empty: got v=%b count=%0d want 0 0", req_valid, dut.u_fifo.count);
    end
`ifdef SDRAM_REQ_LEVEL_EN
    n_cmp++;
    if (q_level !== 3'd0) begin
      n_err++; $display("FAIL pp_level0: got %0d want 0", q_level);
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_full();
    test_reads();
    test_illegal();
    test_reset_mid();
    test_push_pop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
